// File: rtl/skinny_sbox_sched.sv
// skinny_sbox_sched
// -----------------------------------------------------------------------------
// Sequencer that runs one masked Skinny-64 state (NIBBLES nibbles x
// SECURITY_ORDER+1 shares) through a single shared, pipelined HPC1 S-box.
// On an accepted start it latches the masked state. It then issues one nibble
// (all shares) per advancing cycle and forwards fresh randomness. When
// randomness is not valid, it freezes the S-box pipeline through its clock
// enable. Results are collected in order, and done pulses when the last
// nibble has been captured. Shares are never recombined.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   start         begin a run (honoured only in IDLE/DONE)
//   state_in      masked state, share s at [s*4*NIBBLES +: 4*NIBBLES]
//   rnd_in        fresh randomness, rnd_valid marks it fresh
//   rnd_ready     randomness consumed this cycle
//   sbox_x        nibble to S-box, share s at [4s +: 4]
//   sbox_fresh    randomness to S-box
//   sbox_clk_en   S-box gated-clock enable
//   sbox_y        S-box output, same layout as sbox_x
//   result        masked output state, same layout as state_in
//   busy, done    run in progress / one-cycle completion pulse
//   stall_cnt     randomness-stall counter
//
// Optional feature: define SKINNY_SBOX_SCHED_STALL_CNT_EN to build the
// saturating stall counter. Without it, stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
module skinny_sbox_sched #(
    parameter int SECURITY_ORDER = 4,
    parameter int NIBBLES        = 16,
    parameter int LATENCY        = 4,
    parameter int FRESH_W        = 60
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [4*NIBBLES*(SECURITY_ORDER+1)-1:0]     state_in,
    input  logic [FRESH_W-1:0]                          rnd_in,
    input  logic                                        rnd_valid,
    output logic                                        rnd_ready,
    output logic [4*(SECURITY_ORDER+1)-1:0]             sbox_x,
    output logic [FRESH_W-1:0]                          sbox_fresh,
    output logic                                        sbox_clk_en,
    input  logic [4*(SECURITY_ORDER+1)-1:0]             sbox_y,
    output logic [4*NIBBLES*(SECURITY_ORDER+1)-1:0]     result,
    output logic                                        busy,
    output logic                                        done,
    output logic [15:0]                                 stall_cnt
);

    localparam int SHARES  = SECURITY_ORDER + 1;
    localparam int SHARE_W = 4 * NIBBLES;
    localparam int STATE_W = SHARE_W * SHARES;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [STATE_W-1:0]     data_r;
    logic [STATE_W-1:0]     result_r;
    logic [IDX_W-1:0]       in_idx_r;
    logic [IDX_W-1:0]       out_idx_r;
    logic [LATENCY-1:0]     tag_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   adv_s;
    logic                   capture_s;
    logic                   accept_s;
    logic [4*SHARES-1:0]    sbox_x_s;

    // The whole block, S-box pipeline included, moves only when fresh
    // randomness is available; a stall freezes everything in lock-step.
    assign adv_s       = busy_r & rnd_valid;
    // The oldest tag marks a real nibble leaving the S-box pipeline.
    assign capture_s   = adv_s & tag_r[LATENCY-1];

    assign sbox_clk_en = adv_s;
    assign rnd_ready   = adv_s;
    assign sbox_fresh  = rnd_in;
    assign sbox_x      = sbox_x_s;
    assign result      = result_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Next-state logic and start acceptance.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = state_r;
                end
            end
            ST_RUN: begin
                if (adv_s && (in_idx_r == LAST_IDX)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (capture_s && (out_idx_r == LAST_IDX)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Select nibble in_idx of every share of the latched state while issuing.
    always_comb begin
        sbox_x_s = '0;
        if (state_r == ST_RUN) begin
            for (int s = 0; s < SHARES; s++) begin
                sbox_x_s[4*s +: 4] = data_r[s*SHARE_W + 4*int'(in_idx_r) +: 4];
            end
        end else begin
            sbox_x_s = '0;
        end
    end

    // FSM state register with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
            // Pulse only on entry so that lingering in DONE stays quiet.
            done_r  <= (state_s == ST_DONE) && (state_r != ST_DONE);
        end
    end

    // Datapath: latch input, walk the indices, shift tags, capture results.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r    <= '0;
            result_r  <= '0;
            in_idx_r  <= '0;
            out_idx_r <= '0;
            tag_r     <= '0;
        end else if (accept_s) begin
            // result_r is kept: the previous run stays visible until overwritten.
            data_r    <= state_in;
            in_idx_r  <= '0;
            out_idx_r <= '0;
            tag_r     <= '0;
        end else if (adv_s) begin
            // A tag of 1 follows each issued nibble; DRAIN pushes bubbles.
            tag_r <= LATENCY'({tag_r, (state_r == ST_RUN)});
            if (state_r == ST_RUN) begin
                in_idx_r <= in_idx_r + IDX_W'(1);
            end
            if (capture_s) begin
                for (int s = 0; s < SHARES; s++) begin
                    result_r[s*SHARE_W + 4*int'(out_idx_r) +: 4] <= sbox_y[4*s +: 4];
                end
                out_idx_r <= out_idx_r + IDX_W'(1);
            end
        end
    end

`ifdef SKINNY_SBOX_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of busy cycles that had to wait for randomness.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (accept_s) begin
            stall_cnt_r <= 16'h0000;
        end else if (busy_r && !rnd_valid && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/skinny_sbox_sched.md
# skinny_sbox_sched

Sequencer that runs one masked Skinny-64 state, 16 nibbles × (SECURITY_ORDER+1) shares, through a single shared pipelined HPC1 S-box instance, one nibble per advancing cycle. It latches the masked state on `start`, issues nibbles in order and forwards fresh randomness to the S-box. It freezes the S-box pipeline through a clock-enable whenever randomness is unavailable, collects results in order and raises `done`. It sits between the round-function control and the masked S-box gadget in the masked Skinny core.

## Interface
- `SECURITY_ORDER`, 4: masking order d; share count S = d+1.
- `NIBBLES`, 16: nibbles per state.
- `LATENCY`, 4: S-box pipeline depth in enabled cycles.
- `FRESH_W`, 60: fresh-randomness width consumed by the S-box per enabled cycle.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE/DONE.
- `state_in`  in  4·NIBBLES·S  masked state; share s at bits [s·4·NIBBLES +: 4·NIBBLES], nibble i at [4i+:4] within a share.
- `rnd_in`  in  FRESH_W  fresh randomness.
- `rnd_valid`  in  1  `rnd_in` is fresh this cycle.
- `rnd_ready`  out  1  `rnd_in` consumed this cycle.
- `sbox_x`  out  4·S  nibble to S-box; share s at [4s+:4].
- `sbox_fresh`  out  FRESH_W  randomness to S-box.
- `sbox_clk_en`  out  1  enable for the S-box gated clock.
- `sbox_y`  in  4·S  S-box output, same layout as `sbox_x`.
- `result`  out  4·NIBBLES·S  masked output state, same layout as `state_in`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse: `result` complete.
- `stall_cnt`  out  16  randomness-stall counter (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start`: latch `state_in`, clear `in_idx`, `out_idx` and all tags. Move to RUN.
- Advance condition: `adv = busy & rnd_valid`. Outputs: `sbox_clk_en = rnd_ready = adv`, `sbox_fresh = rnd_in` (combinational).
- `sbox_x` = nibble `in_idx` of the latched state, all shares, in RUN. It is all-zero otherwise.
- RUN, `adv`: push tag 1 into the LATENCY-deep tag shift register and increment `in_idx`. At `in_idx = NIBBLES-1` move to DRAIN.
- RUN/DRAIN, `adv` = 0: tags, indices and state hold. The S-box pipeline is frozen by `sbox_clk_en`.
- Capture: on `adv` with the oldest tag set, write `sbox_y` into `result` nibble `out_idx` and increment `out_idx`.
- DRAIN, `adv`: push tag 0. When the capture of nibble NIBBLES-1 happens, move to DONE.
- DONE: `done`=1 for exactly its first cycle. `result` is held until the next accepted `start`. `busy`=0.
- `start` while RUN/DRAIN: ignored.
- `start` in the same cycle as `rst`: `rst` wins.
- Shares pass through without recombination. The block never XORs shares together.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `sbox_clk_en`=0, `rnd_ready`=0, `result`=0, `sbox_x`=0, `stall_cnt`=0, tags cleared.
- `rst` mid-run aborts the run. No `done` is produced.
- `start` sampled at the end of cycle 0: `busy`=1 from cycle 1. Issues occur in cycles 1..NIBBLES.
- A nibble issued in cycle k is captured at the end of the LATENCY-th enabled cycle after k.
- No stalls, defaults: last capture at the end of cycle 20, `done`=1 in cycle 21. Latency = NIBBLES+LATENCY+1.
- Each cycle with `busy & !rnd_valid` adds exactly one cycle of latency.

## Configuration
- `SKINNY_SBOX_SCHED_STALL_CNT_EN` defined: `stall_cnt` increments in every cycle with `busy & !rnd_valid` and saturates at 16'hFFFF. It is cleared on accepted `start` and on `rst`.
- Macro undefined: `stall_cnt` is tied to 0 and no counter logic is built.

## Test plan
- S-box model: ideal LATENCY-4 Skinny S-box per share-sum, `rnd_valid`=1 throughout. Stimulus: share 0 = 64'h0123456789ABCDEF, other shares 0, `start` in cycle 0. Required: `done` in cycle 21 and XOR of `result` shares = 64'hC6901A2B385D4E7F.
- Same input, random sharing (share 0 = value XOR shares 1..4). Required: unmasked `result` = 64'hC6901A2B385D4E7F, and `result` shares are not all equal to their inputs.
- `rnd_valid`=0 for cycles 6-8. Required: `sbox_clk_en`=0 in those cycles, `done` in cycle 24, correct result, `stall_cnt`=3 with the macro and 0 without.
- `rst` in cycle 10 of a run. Required: cycle 11 `busy`=0, `result`=0, no `done`. A new `start` then completes normally in 21 cycles.
- `start` pulsed in cycle 5 of a run. Required: ignored, and the original run finishes in cycle 21.
- `start` in the DONE cycle. Required: new run accepted, `busy`=1 the next cycle, previous `result` held until the first new capture.
